// File: rtl/adder_arbiter_if.sv
// Request/response bundle for adder_arbiter: two operand requesters and one
// valid/ready response channel. The arbiter takes the slave side.
interface adder_arbiter_if #(
  parameter int WIDTH = 6
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_cin;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_cin;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_sum;
  logic             rsp_cout;
  logic             rsp_g;
  logic             rsp_p;
  logic             rsp_ovf;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_cin,
    input  req1_valid, req1_a, req1_b, req1_cin,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_g, rsp_p, rsp_ovf
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_cin,
    output req1_valid, req1_a, req1_b, req1_cin,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_g, rsp_p, rsp_ovf
  );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin arbiter in front of one shared carry-lookahead adder stage.
// Define ADDER_ARB_OVF_EN to build the signed-overflow flag; otherwise rsp_ovf is 0.
module adder_arbiter #(
  parameter int WIDTH     = 6,
  parameter int PRIO_INIT = 0
) (
  input logic           clk,
  input logic           rst_n,
  adder_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  localparam logic LAST_ID_INIT = (PRIO_INIT == 0) ? 1'b1 : 1'b0;

  state_t           state;
  logic             last_id;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             cin_q;
  logic             id_q;

  logic             grant0;
  logic             grant1;
  logic             take0;
  logic             take1;

  logic [WIDTH-1:0] gen;
  logic [WIDTH-1:0] prop;
  logic [WIDTH-1:0] half;
  logic [WIDTH:0]   carry;
  logic             grp_g;
  logic [WIDTH-1:0] sum_next;

  // On a tie, the requester that was not served last wins.
  always_comb begin
    grant0 = bus.req0_valid & (~bus.req1_valid | last_id);
    grant1 = bus.req1_valid & (~bus.req0_valid | ~last_id);
  end

  assign take0          = rst_n & (state == IDLE) & grant0;
  assign take1          = rst_n & (state == IDLE) & grant1;
  assign bus.req0_ready = take0;
  assign bus.req1_ready = take1;

  // NOTE: every variable gets a value before the loop so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    gen      = a_q & b_q;
    prop     = a_q | b_q;
    half     = a_q ^ b_q;
    carry    = '0;
    grp_g    = 1'b0;
    carry[0] = cin_q;
    for (int i = 0; i < WIDTH; i++) begin
      carry[i+1] = gen[i] | (prop[i] & carry[i]);
      grp_g      = gen[i] | (prop[i] & grp_g);
    end
    sum_next = half ^ carry[WIDTH-1:0];
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      last_id       <= LAST_ID_INIT;
      a_q           <= '0;
      b_q           <= '0;
      cin_q         <= 1'b0;
      id_q          <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= 1'b0;
      bus.rsp_sum   <= '0;
      bus.rsp_cout  <= 1'b0;
      bus.rsp_g     <= 1'b0;
      bus.rsp_p     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (take0) begin
            a_q   <= bus.req0_a;
            b_q   <= bus.req0_b;
            cin_q <= bus.req0_cin;
            id_q  <= 1'b0;
            state <= CALC;
          end else if (take1) begin
            a_q   <= bus.req1_a;
            b_q   <= bus.req1_b;
            cin_q <= bus.req1_cin;
            id_q  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          bus.rsp_id    <= id_q;
          bus.rsp_sum   <= sum_next;
          bus.rsp_cout  <= carry[WIDTH];
          bus.rsp_g     <= grp_g;
          bus.rsp_p     <= &prop;
          bus.rsp_valid <= 1'b1;
          state         <= RESP;
        end
        RESP: begin
          // Results stay frozen until the consumer takes them.
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            last_id       <= bus.rsp_id;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ADDER_ARB_OVF_EN
  logic ovf_q;

  // Two's-complement overflow: carry into the sign bit differs from carry out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (state == CALC) begin
      ovf_q <= carry[WIDTH] ^ carry[WIDTH-1];
    end
  end

  assign bus.rsp_ovf = ovf_q;
`else
  assign bus.rsp_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter: accepts push an arithmetic-model result,
// response handshakes pop and compare it.
module tb_adder_arbiter;

  localparam int W = 6;

  typedef struct {
    logic         id;
    logic [W-1:0] sum;
    logic         cout;
    logic         g;
    logic         p;
    logic         ovf;
    int           acc_cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_pass;
  int   n_rsp;
  logic rv_prev;

  exp_t sb[$];
  exp_t mon_e;
  logic grant_log[$];
  int   acc_log[$];

  adder_arbiter_if #(.WIDTH(W)) bus ();

  adder_arbiter #(.WIDTH(W), .PRIO_INIT(0)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic exp_t model(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input int acc);
    exp_t       e;
    logic [W:0] full;
    logic [W:0] nocin;
    full      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    nocin     = {1'b0, a} + {1'b0, b};
    e.id      = id;
    e.sum     = full[W-1:0];
    e.cout    = full[W];
    e.g       = nocin[W];
    e.p       = ((a | b) == {W{1'b1}});
`ifdef ADDER_ARB_OVF_EN
    e.ovf     = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
`else
    e.ovf     = 1'b0;
`endif
    e.acc_cyc = acc;
    return e;
  endfunction

  // Monitor: sample away from the rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.req0_valid && bus.req0_ready) begin
        sb.push_back(model(1'b0, bus.req0_a, bus.req0_b, bus.req0_cin, cyc));
        grant_log.push_back(1'b0);
        acc_log.push_back(cyc);
      end
      if (bus.req1_valid && bus.req1_ready) begin
        sb.push_back(model(1'b1, bus.req1_a, bus.req1_b, bus.req1_cin, cyc));
        grant_log.push_back(1'b1);
        acc_log.push_back(cyc);
      end
      if (bus.req0_ready && bus.req1_ready) check("dual_grant", 1, 0);
      if (bus.rsp_valid) begin
        check("busy_rdy", {30'd0, bus.req0_ready, bus.req1_ready}, 0);
        if (!rv_prev) begin
          if (sb.size() == 0) check("spurious_rsp", 1, 0);
          else check("latency", cyc - sb[0].acc_cyc, 2);
        end
        if (bus.rsp_ready && sb.size() > 0) begin
          mon_e = sb.pop_front();
          check("rsp_id", bus.rsp_id, mon_e.id);
          check("rsp_sum", bus.rsp_sum, mon_e.sum);
          check("rsp_cout", bus.rsp_cout, mon_e.cout);
          check("rsp_g", bus.rsp_g, mon_e.g);
          check("rsp_p", bus.rsp_p, mon_e.p);
          check("rsp_ovf", bus.rsp_ovf, mon_e.ovf);
          n_rsp++;
        end
      end
      rv_prev = bus.rsp_valid;
    end else begin
      rv_prev = 1'b0;
    end
  end

  task automatic wait_hs(input logic id);
    int i;
    for (i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((id == 1'b0) ? bus.req0_ready : bus.req1_ready) break;
    end
    check("hs_timeout", (i < 20), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic id, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    if (id == 1'b0) begin
      bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_cin = cin;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_cin = cin;
    end
  endtask

  task automatic send(input logic id, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    drive(id, a, b, cin);
    wait_hs(id);
    if (id == 1'b0) bus.req0_valid = 1'b0;
    else bus.req1_valid = 1'b0;
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 30; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !bus.rsp_valid) break;
    end
    check("drain_timeout", (i < 30), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [W+4:0] snap;
    int           rsp_before;
    int           i;

    cyc = 0; n_checks = 0; n_pass = 0; n_rsp = 0; rv_prev = 1'b0;
    rst_n = 1'b0;
    bus.rsp_ready  = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_a = '0; bus.req0_b = '0; bus.req0_cin = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_a = '0; bus.req1_b = '0; bus.req1_cin = 1'b0;

    // Reset state: readys held low even with valids asserted.
    @(negedge clk);
    @(negedge clk);
    check("rst_rdy", {30'd0, bus.req0_ready, bus.req1_ready}, 0);
    check("rst_valid", bus.rsp_valid, 0);
    check("rst_id_sum", {bus.rsp_id, bus.rsp_sum}, 0);
    check("rst_flags", {bus.rsp_cout, bus.rsp_g, bus.rsp_p, bus.rsp_ovf}, 0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single request.
    send(1'b0, 6'd5, 6'd9, 1'b1);
    drain();

    // Wrap-around under backpressure, with req0 waiting behind it.
    bus.rsp_ready = 1'b0;
    send(1'b1, 6'h3F, 6'h01, 1'b0);
    for (i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) break;
    end
    check("bp_rsp_timeout", (i < 20), 1);
    snap = {bus.rsp_id, bus.rsp_sum, bus.rsp_cout, bus.rsp_g, bus.rsp_p, bus.rsp_ovf};
    @(posedge clk);
    #1;
    drive(1'b0, 6'd7, 6'd2, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_stable", {bus.rsp_id, bus.rsp_sum, bus.rsp_cout, bus.rsp_g, bus.rsp_p, bus.rsp_ovf}, snap);
      check("bp_valid", bus.rsp_valid, 1);
    end
    rsp_before = n_rsp;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_done", n_rsp - rsp_before, 1);
    wait_hs(1'b0);
    bus.req0_valid = 1'b0;
    drain();

    // Continuous tie from reset: grants alternate, 3 cycles apart.
    do_reset();
    grant_log.delete();
    acc_log.delete();
    drive(1'b0, 6'd1, 6'd2, 1'b0);
    drive(1'b1, 6'h20, 6'h20, 1'b1);
    for (i = 0; i < 40; i++) begin
      @(negedge clk);
      if (grant_log.size() >= 4) break;
    end
    check("alt_timeout", (i < 40), 1);
    @(posedge clk);
    #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    if (grant_log.size() >= 4) begin
      for (int k = 0; k < 4; k++) begin
        check("alt_id", grant_log[k], k % 2);
        if (k > 0) check("alt_gap", acc_log[k] - acc_log[k-1], 3);
      end
    end
    drain();

    // Overflow case; also leaves last_id = 0.
    send(1'b0, 6'h1F, 6'h01, 1'b0);
    drain();

    // Reset while in CALC: result discarded, PRIO_INIT wins the next tie.
    send(1'b0, 6'd9, 6'd9, 1'b0);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("midrst_valid", bus.rsp_valid, 0);
    check("midrst_id_sum", {bus.rsp_id, bus.rsp_sum}, 0);
    check("midrst_flags", {bus.rsp_cout, bus.rsp_g, bus.rsp_p, bus.rsp_ovf}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("midrst_no_rsp", bus.rsp_valid, 0);
    end
    @(posedge clk);
    #1;
    grant_log.delete();
    drive(1'b0, 6'd3, 6'd4, 1'b1);
    drive(1'b1, 6'd10, 6'd20, 1'b0);
    for (i = 0; i < 20; i++) begin
      @(negedge clk);
      if (grant_log.size() >= 1) break;
    end
    check("tie_timeout", (i < 20), 1);
    @(posedge clk);
    #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    if (grant_log.size() >= 1) check("tie_after_rst", grant_log[0], 0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
